// File: rtl/vga_ctrl_pkg.sv
// Shared definitions for the VGA source-select path: state encoding and the
// default timing constants used by both the button counter and the selector.
package vga_ctrl_pkg;

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] BLANK    = 2'd1;
  localparam logic [1:0] SETTLE   = 2'd2;
  localparam logic [1:0] WAIT_REL = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE     = IDLE,
    ST_BLANK    = BLANK,
    ST_SETTLE   = SETTLE,
    ST_WAIT_REL = WAIT_REL
  } vga_state_e;

  localparam int VGA_SW_GAP  = 64;
  localparam int VGA_NUM_SRC = 2;

endpackage

// File: rtl/vga_gap_timer.sv
// Guard-interval down-counter: start loads GAP-1, done is high once the count
// has drained, so a started interval reports done on its GAP-th cycle.
module vga_gap_timer #(
  parameter int GAP = 64
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic start_i,
  output logic done_o
);

  localparam int CW = $clog2(GAP + 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (start_i) begin
      cnt_d = CW'(GAP - 1);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = (cnt_q == '0);

endmodule

// File: rtl/vga_src_sel_ctrl.sv
// VGA source selector: each qualified press advances the source index, with
// the output blanked for a guard interval on both sides of the change.
//
// state    | meaning
// IDLE     | output live, waiting for a fresh press
// BLANK    | output blanked, old source still selected
// SETTLE   | output blanked, new source selected
// WAIT_REL | switch done, waiting for the press to be released
module vga_src_sel_ctrl
  import vga_ctrl_pkg::*;
#(
  parameter  int NUM_SRC = VGA_NUM_SRC,
  parameter  int SW_GAP  = VGA_SW_GAP,
  localparam int SEL_W   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic             i_clk_32k,
  input  logic             i_rst_n,
  input  logic             i_vga_btn_cnt_en,
  input  logic             i_vga_src_lock,
  output logic [SEL_W-1:0] o_vga_sel,
  output logic             o_vga_oe,
  output logic             o_vga_busy,
  output logic             o_vga_sw_pulse
);

  localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(NUM_SRC - 1);

  vga_state_e       state_q;
  logic [SEL_W-1:0] sel_q;
  logic             oe_q;
  logic             busy_q;
  logic             pulse_q;
  logic             en_prev_q;

  logic rise;
  logic gap_start;
  logic gap_done;

  assign rise      = i_vga_btn_cnt_en & ~en_prev_q;
  assign gap_start = ((state_q == ST_IDLE) & rise & ~i_vga_src_lock) |
                     ((state_q == ST_BLANK) & gap_done);

  vga_gap_timer #(
    .GAP (SW_GAP)
  ) u_gap_timer (
    .clk_i   (i_clk_32k),
    .rst_ni  (i_rst_n),
    .start_i (gap_start),
    .done_o  (gap_done)
  );

  // en_prev_q resets high so a press already held at reset release is ignored.
  always_ff @(posedge i_clk_32k) begin
    if (!i_rst_n) begin
      state_q   <= ST_IDLE;
      sel_q     <= '0;
      oe_q      <= 1'b1;
      busy_q    <= 1'b0;
      pulse_q   <= 1'b0;
      en_prev_q <= 1'b1;
    end else begin
      en_prev_q <= i_vga_btn_cnt_en;
      pulse_q   <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (rise && !i_vga_src_lock) begin
            state_q <= ST_BLANK;
            oe_q    <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        ST_BLANK: begin
          if (gap_done) begin
            sel_q   <= (sel_q == SEL_LAST) ? '0 : sel_q + SEL_W'(1);
            state_q <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (gap_done) begin
            oe_q    <= 1'b1;
            busy_q  <= 1'b0;
            pulse_q <= 1'b1;
            state_q <= ST_WAIT_REL;
          end
        end
        ST_WAIT_REL: begin
          if (!i_vga_btn_cnt_en) begin
            state_q <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          oe_q    <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign o_vga_sel      = sel_q;
  assign o_vga_oe       = oe_q;
  assign o_vga_busy     = busy_q;
  assign o_vga_sw_pulse = pulse_q;

endmodule

// File: doc/vga_src_sel_ctrl.md
Name: vga_src_sel_ctrl

Overview:
- Downstream consumer of the VGA button long-press qualifier on the 32 kHz domain.
- Each qualified press (rising edge of the qualifier's enable) advances the VGA source select by one, wrapping at the last source.
- The VGA output is blanked for a fixed guard interval before and after the select change, and a completion pulse is emitted.
- Drives the VGA source mux and the output buffer enable.

Parameters:
- NUM_SRC, 2, number of selectable VGA sources (>=2); o_vga_sel wraps from NUM_SRC-1 to 0.
- SW_GAP, 64, blanking cycles before and after the select change (>=1).
- SEL_W, $clog2(NUM_SRC) (min 1), width of o_vga_sel (derived localparam, not overridden).

Ports:
- i_clk_32k  in  1  32 kHz system clock; all logic on rising edge.
- i_rst_n  in  1  reset; synchronous, active-low.
- i_vga_btn_cnt_en  in  1  qualified long-press level from the button counter stage; high while the press remains qualified.
- i_vga_src_lock  in  1  high = switching inhibited (e.g. during power sequencing).
- o_vga_sel  out  SEL_W  current VGA source index.
- o_vga_oe  out  1  VGA output enable; low while blanking.
- o_vga_busy  out  1  high in BLANK and SETTLE.
- o_vga_sw_pulse  out  1  one-cycle pulse marking completion of a switch.

Behaviour:
- Timing reference: cycle k is the register state after the k-th rising edge. All outputs are registered.
- Reset (i_rst_n low at a rising edge) forces: state=IDLE, o_vga_sel=0, o_vga_oe=1, o_vga_busy=0, o_vga_sw_pulse=0, gap counter=0, en_d=1.
  - en_d is the registered previous value of i_vga_btn_cnt_en.
  - en_d resets to 1 so that an enable already high when reset releases does not trigger a switch.
- Reset mid-sequence aborts immediately to these reset values; the partial switch is discarded.
- Trigger: rise = i_vga_btn_cnt_en & ~en_d, evaluated only in IDLE.
- IDLE:
  - rise & ~lock: go to BLANK, o_vga_oe<=0, o_vga_busy<=1, counter<=0.
  - rise & lock (including simultaneous assertion): ignored and not remembered; remain in IDLE.
- BLANK:
  - Counter increments each cycle.
  - When counter==SW_GAP-1: o_vga_sel<=(o_vga_sel==NUM_SRC-1)?0:o_vga_sel+1, counter<=0, go to SETTLE.
  - BLANK lasts exactly SW_GAP cycles.
- SETTLE:
  - Counter increments each cycle.
  - When counter==SW_GAP-1: o_vga_oe<=1, o_vga_busy<=0, o_vga_sw_pulse<=1, go to WAIT_REL.
- WAIT_REL:
  - o_vga_sw_pulse<=0.
  - Return to IDLE when i_vga_btn_cnt_en==0; otherwise stay.
- Resulting latency, with rise sampled at cycle N:
  - oe low from N+1.
  - sel changes at N+SW_GAP+1.
  - oe high and pulse at N+2*SW_GAP+1.
  - pulse is high for exactly one cycle.
- Changes to enable or lock during BLANK/SETTLE have no effect; the sequence always completes.
  - If enable is already low on entry to WAIT_REL, return to IDLE on the next cycle.
- At most one switch per press. A new switch requires enable low, then a fresh rise while in IDLE.
- en_d updates every cycle in all states.
- Unused state encodings recover to IDLE, with oe=1 and busy=0.

Decomposition:
- Package vga_ctrl_pkg holds:
  - state encoding localparams: IDLE=2'd0, BLANK=2'd1, SETTLE=2'd2, WAIT_REL=2'd3;
  - default SW_GAP and NUM_SRC constants, shared with the button counter stage.
- One natural sub-module, vga_gap_timer:
  - parameterised down-counter (width $clog2(SW_GAP+1));
  - inputs: start, sync reset; output: done.
  - Instantiated once and reused for the BLANK and SETTLE intervals.

Test Plan:
- Basic switch (SW_GAP=4, NUM_SRC=2): reset, then raise enable so the rise is sampled at cycle 10 -> oe=0 at 11-18; sel 0->1 at 15; oe=1 and pulse=1 at 19 only; busy high 11-18.
- Wrap (NUM_SRC=3): three separate presses, enable released between presses -> sel 0->1->2->0; exactly three pulses.
- Held press: enable held high for 200 cycles -> exactly one switch; no second pulse until enable drops and rises again.
- Lock: lock=1 with a rise in IDLE -> sel unchanged, oe stays 1, no pulse; lock asserted at BLANK cycle 2 -> sequence completes normally.
- Enable high at reset release -> no switch; after enable low then high -> one switch.
- Reset mid-SETTLE (SW_GAP=4, i_rst_n low at cycle 16) -> at 17: sel=0, oe=1, busy=0, pulse=0, state IDLE.
